// File: rtl/tod_clock_12h.sv
// tod_clock_12h: 12-hour BCD time-of-day counter with a 1 s prescaler and
// a synchronous set port. All outputs are registered.
// Optional build macro TOD_SET_CHECK_EN: rejects illegal set values and
// pulses set_err instead of loading them.
module tod_clock_12h #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned PRE_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_en,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic       set_pm,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       pm,
  output logic       sec_tick
`ifdef TOD_SET_CHECK_EN
  ,
  output logic       set_err
`endif
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       hr_q, hr_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       sec_q, sec_d;
  logic             pm_q, pm_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             min_carry;
  logic             hr_carry;
  logic             set_ok;
  logic             load;

`ifdef TOD_SET_CHECK_EN
  logic             err_q, err_d;
  logic             hr_ok;
  logic             min_ok;

  // Set value legality: hours 01..12 in BCD, minutes tens 0..5 and units 0..9
  always_comb begin
    hr_ok  = ((set_hours[7:4] == 4'd0) && (set_hours[3:0] != 4'd0) && (set_hours[3:0] <= 4'd9)) ||
             ((set_hours[7:4] == 4'd1) && (set_hours[3:0] <= 4'd2));
    min_ok = (set_minutes[7:4] <= 4'd5) && (set_minutes[3:0] <= 4'd9);
    set_ok = hr_ok && min_ok;
    err_d  = set_en && !set_ok;
  end
`else
  assign set_ok = 1'b1;
`endif

  assign load = set_en && set_ok;
  assign wrap = run && (pre_q == PRE_LAST);

  // Next-state: load has priority; otherwise prescaler runs and time advances on wrap
  always_comb begin
    pre_d     = pre_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pm_d      = pm_q;
    tick_d    = 1'b0;
    min_carry = 1'b0;
    hr_carry  = 1'b0;

    if (load) begin
      pre_d = '0;
      hr_d  = set_hours;
      min_d = set_minutes;
      sec_d = '0;
      pm_d  = set_pm;
    end else if (wrap) begin
      pre_d  = '0;
      tick_d = 1'b1;

      if (sec_q[3:0] == 4'd9) begin
        sec_d[3:0] = '0;
        if (sec_q[7:4] == 4'd5) begin
          sec_d[7:4] = '0;
          min_carry  = 1'b1;
        end else begin
          sec_d[7:4] = sec_q[7:4] + 4'd1;
        end
      end else begin
        sec_d[3:0] = sec_q[3:0] + 4'd1;
      end

      if (min_carry) begin
        if (min_q[3:0] == 4'd9) begin
          min_d[3:0] = '0;
          if (min_q[7:4] == 4'd5) begin
            min_d[7:4] = '0;
            hr_carry   = 1'b1;
          end else begin
            min_d[7:4] = min_q[7:4] + 4'd1;
          end
        end else begin
          min_d[3:0] = min_q[3:0] + 4'd1;
        end
      end

      // 11 -> 12 flips AM/PM; 12 -> 01 keeps it; a units 9 rolls into the tens digit
      if (hr_carry) begin
        if (hr_q == 8'h11) begin
          hr_d = 8'h12;
          pm_d = ~pm_q;
        end else if (hr_q == 8'h12) begin
          hr_d = 8'h01;
        end else if (hr_q[3:0] == 4'd9) begin
          hr_d = {hr_q[7:4] + 4'd1, 4'd0};
        end else begin
          hr_d[3:0] = hr_q[3:0] + 4'd1;
        end
      end
    end else if (run) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // State registers; reset returns to 12:00:00 AM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      hr_q   <= 8'h12;
      min_q  <= '0;
      sec_q  <= '0;
      pm_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      pm_q   <= pm_d;
      tick_q <= tick_d;
    end
  end

`ifdef TOD_SET_CHECK_EN
  // Rejected-set pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign set_err = err_q;
`endif

  assign hours    = hr_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign pm       = pm_q;
  assign sec_tick = tick_q;

endmodule
